// File: rtl/vga_timing_gen.sv
// Pixel-tick divider and 800x525 raster scanner for the Pong display path.
// Every output is registered; hsync/vsync can be delayed to line up with a registered rgb stage.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        p_tick_o,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        video_on_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        line_tick_o,
  output logic        frame_tick_o,
  output logic [15:0] frame_count_o
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             line_wrap, frame_wrap;
  logic             video_on_d, hsync_raw_d, vsync_raw_d;
  logic             p_tick_q, line_tick_q, frame_tick_q, video_on_q;
  logic             hsync_raw_q, vsync_raw_q;

  // Decode works on the next-state coordinates so the registered flags change in the same clk as x/y.
  always_comb begin
    tick  = (div_q >= DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q >= H_LAST) x_d = '0;
      else               x_d = x_q + 10'd1;
      if (y_q > V_LAST)       y_d = '0;
      else if (x_q >= H_LAST) y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    line_wrap     = tick && (x_d == '0);
    frame_wrap    = line_wrap && (y_d == '0);
    frame_count_d = frame_wrap ? frame_count_q + 16'd1 : frame_count_q;
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_raw_d   = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_raw_d   = !((y_d >= VS_START) && (y_d < VS_END));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      p_tick_q      <= 1'b0;
      line_tick_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
      video_on_q    <= 1'b1;
      hsync_raw_q   <= 1'b1;
      vsync_raw_q   <= 1'b1;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      p_tick_q      <= tick;
      line_tick_q   <= line_wrap;
      frame_tick_q  <= frame_wrap;
      video_on_q    <= video_on_d;
      hsync_raw_q   <= hsync_raw_d;
      vsync_raw_q   <= vsync_raw_d;
    end
  end

  // The delay stages advance once per pixel, so the lag is counted in pixels rather than clks.
  if (SYNC_DELAY > 0) begin : g_delay
    logic [SYNC_DELAY-1:0] hdly_q, vdly_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        hdly_q <= '1;
        vdly_q <= '1;
      end else if (tick) begin
        hdly_q[0] <= hsync_raw_q;
        vdly_q[0] <= vsync_raw_q;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hdly_q[i] <= hdly_q[i-1];
          vdly_q[i] <= vdly_q[i-1];
        end
      end
    end

    assign hsync_o = hdly_q[SYNC_DELAY-1];
    assign vsync_o = vdly_q[SYNC_DELAY-1];
  end else begin : g_nodelay
    assign hsync_o = hsync_raw_q;
    assign vsync_o = vsync_raw_q;
  end

  assign p_tick_o      = p_tick_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign video_on_o    = video_on_q;
  assign line_tick_o   = line_tick_q;
  assign frame_tick_o  = frame_tick_q;
  assign frame_count_o = frame_count_q;

endmodule
